// File: rtl/bf16_result_packer.sv
// Packs BF16 lane results four-to-a-word into a fall-through FIFO and throttles lane issue.
// Optional: define BF16_PACK_STATS_EN to add the zero_cnt output (count of +/-0 results).
module bf16_result_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int ELEMS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lane_issue,
  input  logic [15:0]         lane_result,
  input  logic                lane_valid,
  input  logic                flush,
  output logic                issue_ok,
  output logic [ELEMS*16-1:0] wb_data,
  output logic [ELEMS-1:0]    wb_mask,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                overflow,
  output logic                idle
`ifdef BF16_PACK_STATS_EN
  ,
  output logic [15:0]         zero_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(PIPE_DEPTH + 1);
  localparam int WW = ELEMS * 16;

  logic [3:0][15:0]    r_pkData;
  logic [2:0]          r_pkCnt;
  logic [WW+ELEMS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;
  logic [IW-1:0]       r_inflight;
  logic                r_overflow;

  logic [3:0][15:0]    w_pkData;
  logic [2:0]          w_pkCnt;
  logic [3:0]          w_mask;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_doPush;
  logic                w_drop;
  logic [CW-1:0]       w_free;
  logic [15:0]         w_need;
  logic [15:0]         w_room;
  logic [WW+ELEMS-1:0] w_head;

  // The incoming element lands before any close decision, so flush and a 4th element see it.
  always_comb begin
    w_pkData = r_pkData;
    w_pkCnt  = r_pkCnt;
    if (lane_valid) begin
      w_pkData[r_pkCnt[1:0]] = lane_result;
      w_pkCnt                = r_pkCnt + 3'd1;
    end
    w_push = (w_pkCnt == 3'd4) || (flush && (w_pkCnt != 3'd0));
    case (w_pkCnt)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd3:    w_mask = 4'b0111;
      3'd4:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = (r_count != '0) && wb_ready;
  assign w_doPush = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= {w_mask, w_pkData};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkData   <= '0;
      r_pkCnt    <= 3'd0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pkData <= w_push ? '0 : w_pkData;
      r_pkCnt  <= w_push ? 3'd0 : w_pkCnt;
      if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_doPush, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      case ({lane_issue, lane_valid})
        2'b10:   if (r_inflight != '1) r_inflight <= r_inflight + IW'(1);
        2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Capacity test rearranged as inflight + pk_cnt < free_words*4 so nothing goes negative.
  assign w_free   = CW'(FIFO_DEPTH) - r_count;
  assign w_need   = 16'(r_inflight) + 16'(r_pkCnt);
  assign w_room   = 16'({w_free, 2'b00});
  assign issue_ok = (w_need < w_room) && (r_inflight < IW'(PIPE_DEPTH));

  assign w_head   = r_mem[r_rdPtr];
  assign wb_valid = (r_count != '0);
  assign wb_data  = wb_valid ? w_head[WW-1:0] : '0;
  assign wb_mask  = wb_valid ? w_head[WW+ELEMS-1:WW] : '0;
  assign overflow = r_overflow;
  assign idle     = (r_inflight == '0) && (r_pkCnt == 3'd0) && (r_count == '0);

`ifdef BF16_PACK_STATS_EN
  logic [15:0] r_zeroCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zeroCnt <= 16'h0000;
    end else if (lane_valid && ((lane_result == 16'h0000) || (lane_result == 16'h8000))
                 && (r_zeroCnt != 16'hFFFF)) begin
      r_zeroCnt <= r_zeroCnt + 16'd1;
    end
  end

  assign zero_cnt = r_zeroCnt;
`endif

endmodule

// File: tb/tb_bf16_result_packer.sv
// Self-checking bench for bf16_result_packer: directed vector table, corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_bf16_result_packer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        lane_issue;
  logic [15:0] lane_result;
  logic        lane_valid;
  logic        flush;
  logic        issue_ok;
  logic [63:0] wb_data;
  logic [3:0]  wb_mask;
  logic        wb_valid;
  logic        wb_ready;
  logic        overflow;
  logic        idle;
`ifdef BF16_PACK_STATS_EN
  logic [15:0] zero_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bf16_result_packer #(.FIFO_DEPTH(DEPTH), .PIPE_DEPTH(4), .ELEMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .lane_issue(lane_issue), .lane_result(lane_result),
    .lane_valid(lane_valid), .flush(flush), .issue_ok(issue_ok), .wb_data(wb_data),
    .wb_mask(wb_mask), .wb_valid(wb_valid), .wb_ready(wb_ready), .overflow(overflow),
    .idle(idle)
`ifdef BF16_PACK_STATS_EN
    , .zero_cnt(zero_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: elements waiting to be packed, queue of packed words, counters.
  typedef struct {
    logic [63:0] d;
    logic [3:0]  m;
  } word_t;

  logic [15:0] mElems[$];
  word_t       mFifo[$];
  int          mInflight;
  bit          mOverflow;
  int          mZero;

  function automatic bit modelIssueOk();
    int cap;
    cap = (DEPTH - mFifo.size()) * 4 - mElems.size();
    return (mInflight < cap) && (mInflight < 4);
  endfunction

  task automatic modelReset();
    mElems.delete();
    mFifo.delete();
    mInflight = 0;
    mOverflow = 1'b0;
    mZero     = 0;
  endtask

  task automatic modelStep(input bit iss, input bit val, input logic [15:0] res,
                           input bit fl, input bit rdy);
    bit    pop;
    word_t w;
    pop = (mFifo.size() > 0) && rdy;
    if (val) begin
      mElems.push_back(res);
      if ((res == 16'h0000 || res == 16'h8000) && mZero < 65535) mZero++;
    end
    if (pop) void'(mFifo.pop_front());
    if (mElems.size() == 4 || (fl && mElems.size() > 0)) begin
      w.d = 64'h0;
      for (int i = 0; i < mElems.size(); i++) w.d = w.d | (64'(mElems[i]) << (16 * i));
      w.m = 4'((1 << mElems.size()) - 1);
      if (mFifo.size() < DEPTH) mFifo.push_back(w);
      else mOverflow = 1'b1;
      mElems.delete();
    end
    if (iss && !val) mInflight++;
    else if (val && !iss && mInflight > 0) mInflight--;
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit v;
    v = (mFifo.size() > 0);
    checkVal("wb_valid", 64'(wb_valid), 64'(v));
    checkVal("wb_data",  wb_data, v ? mFifo[0].d : 64'h0);
    checkVal("wb_mask",  64'(wb_mask), v ? 64'(mFifo[0].m) : 64'h0);
    checkVal("issue_ok", 64'(issue_ok), 64'(modelIssueOk()));
    checkVal("overflow", 64'(overflow), 64'(mOverflow));
    checkVal("idle", 64'(idle),
             64'(mInflight == 0 && mElems.size() == 0 && mFifo.size() == 0));
`ifdef BF16_PACK_STATS_EN
    checkVal("zero_cnt", 64'(zero_cnt), 64'(mZero));
`endif
  endtask

  // Called just after a falling edge: drive, clock, then compare at the next falling edge.
  task automatic applyStimulus(input bit iss, input bit val, input logic [15:0] res,
                               input bit fl, input bit rdy);
    lane_issue  = iss;
    lane_valid  = val;
    lane_result = res;
    flush       = fl;
    wb_ready    = rdy;
    modelStep(iss, val, res, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    lane_issue = 0; lane_valid = 0; lane_result = 0; flush = 0; wb_ready = 0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  // Fill the FIFO with 32 results while obeying issue_ok, with wb_ready held low.
  task automatic fillFifo();
    int results = 0;
    for (int c = 0; c < 300 && results < 32; c++) begin
      bit iss, val;
      iss = modelIssueOk();
      val = (mInflight > 0);
      applyStimulus(iss, val, 16'($urandom), 1'b0, 1'b0);
      if (val) results++;
    end
    checkVal("fill_results", 64'(results), 64'd32);
  endtask

  typedef struct {
    bit          iss, val;
    logic [15:0] res;
    bit          fl, rdy;
    bit          eValid;
    logic [63:0] eData;
    logic [3:0]  eMask;
    bit          eOk, eIdle;
  } vec_t;

  vec_t vec [18];

  initial begin
    logic [63:0] savedHead;
    rst_n = 1'b0;
    vec[0]  = '{1, 0, 16'h0000, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[1]  = '{1, 0, 16'h0000, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[2]  = '{1, 0, 16'h0000, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[3]  = '{1, 0, 16'h0000, 0, 0, 0, 64'h0, 4'h0, 0, 0};
    vec[4]  = '{0, 1, 16'h3F80, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[5]  = '{0, 1, 16'h4000, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[6]  = '{0, 1, 16'h4040, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[7]  = '{0, 1, 16'h4080, 0, 0, 1, 64'h4080_4040_4000_3F80, 4'hF, 1, 0};
    vec[8]  = '{0, 0, 16'h0000, 0, 1, 0, 64'h0, 4'h0, 1, 1};
    vec[9]  = '{1, 1, 16'h3F80, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[10] = '{1, 1, 16'h4000, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[11] = '{1, 1, 16'h4040, 0, 0, 0, 64'h0, 4'h0, 1, 0};
    vec[12] = '{0, 0, 16'h0000, 1, 0, 1, 64'h0000_4040_4000_3F80, 4'h7, 1, 0};
    vec[13] = '{1, 1, 16'h3F80, 0, 0, 1, 64'h0000_4040_4000_3F80, 4'h7, 1, 0};
    vec[14] = '{1, 1, 16'h4000, 1, 0, 1, 64'h0000_4040_4000_3F80, 4'h7, 1, 0};
    vec[15] = '{0, 0, 16'h0000, 0, 1, 1, 64'h0000_0000_4000_3F80, 4'h3, 1, 0};
    vec[16] = '{0, 0, 16'h0000, 0, 1, 0, 64'h0, 4'h0, 1, 1};
    vec[17] = '{0, 0, 16'h0000, 1, 0, 0, 64'h0, 4'h0, 1, 1};

    @(negedge clk);
    doReset();
    checkVal("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkVal("rst_issue_ok", 64'(issue_ok), 64'd1);
    checkVal("rst_idle", 64'(idle), 64'd1);

    // Directed table: full word, partial flushes, no-op flush.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vec[i].iss, vec[i].val, vec[i].res, vec[i].fl, vec[i].rdy);
      checkVal($sformatf("vec%0d_valid", i), 64'(wb_valid), 64'(vec[i].eValid));
      checkVal($sformatf("vec%0d_data", i), wb_data, vec[i].eData);
      checkVal($sformatf("vec%0d_mask", i), 64'(wb_mask), 64'(vec[i].eMask));
      checkVal($sformatf("vec%0d_ok", i), 64'(issue_ok), 64'(vec[i].eOk));
      checkVal($sformatf("vec%0d_idle", i), 64'(idle), 64'(vec[i].eIdle));
    end

    // Fill to capacity, then force a flushed 33rd result into the full FIFO.
    doReset();
    fillFifo();
    checkVal("full_issue_ok", 64'(issue_ok), 64'd0);
    checkVal("full_valid", 64'(wb_valid), 64'd1);
    savedHead = mFifo[0].d;
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    checkVal("drop_overflow", 64'(overflow), 64'd1);
    checkVal("drop_head", wb_data, savedHead);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkVal("drop_drained_idle", 64'(idle), 64'd1);
    checkVal("drop_overflow_sticky", 64'(overflow), 64'd1);

    // Full FIFO, pop coincides with a 4th-element push: no drop, order kept across wrap.
    doReset();
    fillFifo();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hA003, 1'b0, 1'b1);
    checkVal("wrap_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkVal("wrap_idle", 64'(idle), 64'd1);

    // Asynchronous reset mid-stream with 2 ops in flight and 3 elements packed.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h3C00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkVal("pre_rst_idle", 64'(idle), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkVal("async_wb_valid", 64'(wb_valid), 64'd0);
    checkVal("async_wb_data", wb_data, 64'h0);
    checkVal("async_wb_mask", 64'(wb_mask), 64'h0);
    checkVal("async_overflow", 64'(overflow), 64'd0);
    checkVal("async_issue_ok", 64'(issue_ok), 64'd1);
    checkVal("async_idle", 64'(idle), 64'd1);
    lane_issue = 0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BF16_PACK_STATS_EN
    doReset();
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h3F80, 1'b0, 1'b0);
    checkVal("zero_cnt_directed", 64'(zero_cnt), 64'd2);
`endif

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 600; c++) begin
      bit iss, val, fl, rdy;
      logic [15:0] res;
      int pick;
      iss  = modelIssueOk() && ($urandom_range(0, 1) == 1);
      val  = (mInflight > 0) && ($urandom_range(0, 2) != 0);
      pick = $urandom_range(0, 7);
      res  = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'h8000 : 16'($urandom);
      fl   = ($urandom_range(0, 15) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      applyStimulus(iss, val, res, fl, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
